wave_capture_trig: RTL and testbench

Parametrised successor to the audio wave-capture stage. Watches the sample stream for a level crossing with a selectable trigger level and edge, then writes a fixed-depth frame of reduced-width, offset-binary samples into one half of the ping-pong wave RAM. The write interface is registered. Once the frame is complete, the block hands that half to the wave display. It sits between the codec sample source and the wave display RAM.

---
 rtl/wave_capture_if.sv | 29 ++
 rtl/wave_capture_trig.sv | 132 +++++++++++++
 tb/tb_wave_capture_trig.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_capture_if.sv
// Sample-stream and wave-RAM write signals of the wave capture stage.
// master = capture block, slave = its environment (codec source, wave RAM, display).
interface wave_capture_if #(
    parameter int SAMPLE_W   = 16,
    parameter int OUT_W      = 8,
    parameter int DEPTH_LOG2 = 8
);
    logic                  new_sample_ready;
    logic [SAMPLE_W-1:0]   new_sample_in;
    logic [SAMPLE_W-1:0]   trig_level;
    logic                  trig_falling;
    logic                  wave_display_idle;
    logic [DEPTH_LOG2:0]   write_address;
    logic                  write_enable;
    logic [OUT_W-1:0]      write_sample;
    logic                  read_index;
    logic                  capture_done;
    logic                  auto_trig;

    modport master (
        input  new_sample_ready, new_sample_in, trig_level, trig_falling, wave_display_idle,
        output write_address, write_enable, write_sample, read_index, capture_done, auto_trig
    );

    modport slave (
        output new_sample_ready, new_sample_in, trig_level, trig_falling, wave_display_idle,
        input  write_address, write_enable, write_sample, read_index, capture_done, auto_trig
    );
endinterface

// File: rtl/wave_capture_trig.sv
// Level-crossing triggered frame capture into a ping-pong wave RAM.
// Optional auto-trigger after AUTO_TIMEOUT idle samples: define WAVE_CAPTURE_AUTO_TRIG_EN.
module wave_capture_trig #(
    parameter int SAMPLE_W     = 16,
    parameter int OUT_W        = 8,
    parameter int DEPTH_LOG2   = 8,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           reset,
    wave_capture_if.master bus
);
    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_INDEX = DEPTH_LOG2'(DEPTH - 1);
    localparam logic [OUT_W-1:0]      MSB_FLIP   = OUT_W'(1) << (OUT_W - 1);

    typedef enum logic [1:0] {
        ARMED,
        ACTIVE,
        WAIT_DISPLAY
    } state_t;

    state_t                       state;
    logic [DEPTH_LOG2-1:0]        index;
    logic signed [SAMPLE_W-1:0]   prev;
    logic                         prev_valid;

    logic signed [SAMPLE_W-1:0]   sample;
    logic signed [SAMPLE_W-1:0]   level;
    logic [OUT_W-1:0]             stored;
    logic                         level_hit;
    logic                         auto_hit;
    logic                         start;

    assign sample = bus.new_sample_in;
    assign level  = bus.trig_level;
    // Keep the top OUT_W bits and flip the sign bit to get offset binary.
    assign stored = sample[SAMPLE_W-1 -: OUT_W] ^ MSB_FLIP;

`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);
    logic [CNT_W-1:0] armed_count;
    assign auto_hit = (armed_count == CNT_W'(AUTO_TIMEOUT));
`else
    localparam int unused_auto_timeout = AUTO_TIMEOUT;
    assign auto_hit = 1'b0;
`endif

    always_comb begin
        level_hit = 1'b0;
        if (prev_valid) begin
            if (bus.trig_falling)
                level_hit = (prev >= level) && (sample < level);
            else
                level_hit = (prev < level) && (sample >= level);
        end
    end

    assign start = bus.new_sample_ready && (level_hit || auto_hit);

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch below sees the pre-edge values of state, index and read_index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ARMED;
            index             <= '0;
            prev              <= '0;
            prev_valid        <= 1'b0;
            bus.read_index    <= 1'b0;
            bus.write_enable  <= 1'b0;
            bus.write_address <= '0;
            bus.write_sample  <= '0;
            bus.capture_done  <= 1'b0;
            bus.auto_trig     <= 1'b0;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
            armed_count       <= '0;
`endif
        end else begin
            bus.write_enable <= 1'b0;
            bus.capture_done <= 1'b0;
            unique case (state)
                ARMED: begin
                    if (bus.new_sample_ready) begin
                        prev       <= sample;
                        prev_valid <= 1'b1;
                        if (start) begin
                            bus.write_enable  <= 1'b1;
                            bus.write_address <= {~bus.read_index, {DEPTH_LOG2{1'b0}}};
                            bus.write_sample  <= stored;
                            index             <= DEPTH_LOG2'(1);
                            state             <= ACTIVE;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
                            bus.auto_trig     <= !level_hit;
`endif
                        end
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
                        else begin
                            armed_count <= armed_count + 1'b1;
                        end
`endif
                    end
                end
                ACTIVE: begin
                    if (bus.new_sample_ready) begin
                        bus.write_enable  <= 1'b1;
                        bus.write_address <= {~bus.read_index, index};
                        bus.write_sample  <= stored;
                        // Index parks on the last slot rather than wrapping.
                        if (index == LAST_INDEX) begin
                            bus.capture_done <= 1'b1;
                            state            <= WAIT_DISPLAY;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                WAIT_DISPLAY: begin
                    if (bus.wave_display_idle) begin
                        bus.read_index <= ~bus.read_index;
                        index          <= '0;
                        prev_valid     <= 1'b0;
                        state          <= ARMED;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
                        armed_count    <= '0;
`endif
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_capture_trig.sv
// Self-checking bench for wave_capture_trig: vector table, directed frame sequences
// and randomized traffic against a per-strobe behavioural model.
module tb_wave_capture_trig;
    localparam int SW    = 16;
    localparam int OW    = 8;
    localparam int DL    = 8;
    localparam int AT    = 16;
    localparam int DEPTH = 1 << DL;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    wave_capture_if #(.SAMPLE_W(SW), .OUT_W(OW), .DEPTH_LOG2(DL)) bus ();

    wave_capture_trig #(
        .SAMPLE_W    (SW),
        .OUT_W       (OW),
        .DEPTH_LOG2  (DL),
        .AUTO_TIMEOUT(AT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = waiting for trigger, 1 = filling frame, 2 = frame held.
    int m_mode = 0, m_pos = 0, m_last = 0, m_seen = 0;
    bit m_have_last = 0, m_ri = 0, m_auto = 0;
    bit e_we = 0, e_done = 0;
    int e_addr = 0, e_data = 0;

    function automatic int offset_code(input int s);
        return (s + (1 << (SW - 1))) >> (SW - OW);
    endfunction

    task automatic model_step(input bit rst, input bit rdy, input int s, input int lvl,
                              input bit fall, input bit idle);
        bit hit, timeout;
        e_we   = 0;
        e_done = 0;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_last = 0; m_seen = 0;
            m_have_last = 0; m_ri = 0; m_auto = 0;
            e_addr = 0; e_data = 0;
            return;
        end
        case (m_mode)
            0: if (rdy) begin
                hit = m_have_last && (fall ? (m_last >= lvl && s < lvl) : (m_last < lvl && s >= lvl));
                timeout = AUTO_EN && !hit && (m_seen == AT);
                if (hit || timeout) begin
                    e_we = 1; e_addr = (m_ri ? 0 : DEPTH); e_data = offset_code(s);
                    m_auto = timeout; m_pos = 1; m_mode = 1;
                end else begin
                    m_seen++;
                end
                m_last = s; m_have_last = 1;
            end
            1: if (rdy) begin
                e_we = 1; e_addr = (m_ri ? 0 : DEPTH) + m_pos; e_data = offset_code(s);
                if (m_pos == DEPTH - 1) begin
                    e_done = 1; m_mode = 2;
                end else begin
                    m_pos++;
                end
            end
            default: if (idle) begin
                m_ri = !m_ri; m_mode = 0; m_pos = 0; m_have_last = 0; m_seen = 0;
            end
        endcase
    endtask

    task automatic cycle(input bit rst, input bit rdy, input logic [15:0] s,
                         input logic [15:0] lvl, input bit fall, input bit idle);
        @(negedge clk);
        reset                 = rst;
        bus.new_sample_ready  = rdy;
        bus.new_sample_in     = s;
        bus.trig_level        = lvl;
        bus.trig_falling      = fall;
        bus.wave_display_idle = idle;
        model_step(rst, rdy, int'($signed(s)), int'($signed(lvl)), fall, idle);
        @(posedge clk);
        #1;
        check("write_enable", 32'(bus.write_enable), 32'(e_we));
        check("capture_done", 32'(bus.capture_done), 32'(e_done));
        check("read_index", 32'(bus.read_index), 32'(m_ri));
        check("auto_trig", 32'(bus.auto_trig), 32'(m_auto));
        if (e_we) begin
            check("write_address", 32'(bus.write_address), e_addr);
            check("write_sample", 32'(bus.write_sample), e_data);
        end
    endtask

    // Trigger with -5 -> 0x0300 at level 0, then fill the rest of the frame and drain.
    task automatic run_frame(output int first_addr, output int last_addr,
                             output int n_we, output int n_done);
        n_we = 0; n_done = 0; last_addr = -1;
        cycle(0, 1, 16'hFFFB, 16'h0000, 0, 0);
        cycle(0, 1, 16'h0300, 16'h0000, 0, 0);
        first_addr = bus.write_enable ? int'(bus.write_address) : -1;
        n_we += int'(bus.write_enable);
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(0, (i < DEPTH - 1), 16'($urandom), 16'h0000, 0, 0);
            if (bus.write_enable) begin
                n_we++;
                last_addr = int'(bus.write_address);
            end
            n_done += int'(bus.capture_done);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [15:0] s;
        logic [15:0] lvl;
        logic        fall;
        logic        idle;
        logic        we;
        logic [8:0]  addr;
        logic [7:0]  data;
        logic        ri;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int fa, la, nw, nd;
        logic [15:0] lvl;
        bit fall;

        reset = 1'b1;
        bus.new_sample_ready = 0; bus.new_sample_in = '0; bus.trig_level = '0;
        bus.trig_falling = 0; bus.wave_display_idle = 0;

        //          rst rdy sample    level     fal idl we  addr    data   ri
        tbl[0]  = '{1, 1, 16'h0300, 16'h0000, 0, 0, 0, 9'h000, 8'h00, 0};
        tbl[1]  = '{1, 1, 16'h0300, 16'h0000, 0, 0, 0, 9'h000, 8'h00, 0};
        tbl[2]  = '{0, 1, 16'hFFFB, 16'h0000, 0, 0, 0, 9'h000, 8'h00, 0};
        tbl[3]  = '{0, 1, 16'h0300, 16'h0000, 0, 0, 1, 9'h100, 8'h83, 0};
        tbl[4]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 9'h000, 8'h00, 0};
        tbl[5]  = '{1, 0, 16'h0000, 16'h0000, 0, 0, 0, 9'h000, 8'h00, 0};
        tbl[6]  = '{0, 1, 16'h2000, 16'h1000, 1, 0, 0, 9'h000, 8'h00, 0};
        tbl[7]  = '{0, 1, 16'h0FFF, 16'h1000, 1, 0, 1, 9'h100, 8'h8F, 0};
        tbl[8]  = '{1, 0, 16'h0000, 16'h1000, 0, 0, 0, 9'h000, 8'h00, 0};
        tbl[9]  = '{0, 1, 16'h2000, 16'h1000, 0, 0, 0, 9'h000, 8'h00, 0};
        tbl[10] = '{0, 1, 16'h0FFF, 16'h1000, 0, 0, 0, 9'h000, 8'h00, 0};
        tbl[11] = '{0, 0, 16'h0000, 16'h1000, 0, 0, 0, 9'h000, 8'h00, 0};
        tbl[12] = '{1, 0, 16'h0000, 16'h0000, 0, 0, 0, 9'h000, 8'h00, 0};

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rst, tbl[i].rdy, tbl[i].s, tbl[i].lvl, tbl[i].fall, tbl[i].idle);
            check($sformatf("vec%0d_we", i), 32'(bus.write_enable), 32'(tbl[i].we));
            check($sformatf("vec%0d_ri", i), 32'(bus.read_index), 32'(tbl[i].ri));
            if (tbl[i].we) begin
                check($sformatf("vec%0d_addr", i), 32'(bus.write_address), 32'(tbl[i].addr));
                check($sformatf("vec%0d_data", i), 32'(bus.write_sample), 32'(tbl[i].data));
            end
        end

        // Two reset cycles with strobes present, then a full frame and a held hand-off.
        cycle(1, 1, 16'h0300, 16'h0000, 0, 0);
        cycle(1, 1, 16'h0300, 16'h0000, 0, 0);
        check("reset_outputs", {bus.write_enable, bus.capture_done, bus.read_index,
                                bus.auto_trig, bus.write_address, bus.write_sample}, 0);
        run_frame(fa, la, nw, nd);
        check("frame0_first_addr", fa, 32'h100);
        check("frame0_last_addr", la, 32'h1FF);
        check("frame0_writes", nw, DEPTH);
        check("frame0_done_pulses", nd, 1);

        nw = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 16'($urandom), 16'h0000, 0, 0);
            nw += int'(bus.write_enable);
        end
        check("hold_writes", nw, 0);
        cycle(0, 0, 16'h0000, 16'h0000, 0, 1);
        check("pingpong_read_index", 32'(bus.read_index), 1);

        run_frame(fa, la, nw, nd);
        check("frame1_first_addr", fa, 32'h000);
        check("frame1_last_addr", la, 32'h0FF);
        check("frame1_writes", nw, DEPTH);
        cycle(0, 0, 16'h0000, 16'h0000, 0, 1);
        check("pingpong_back", 32'(bus.read_index), 0);
        run_frame(fa, la, nw, nd);
        check("frame2_first_addr", fa, 32'h100);
        cycle(0, 0, 16'h0000, 16'h0000, 0, 1);

        // Abandon a frame after the write at index 100 while read_index = 1.
        cycle(0, 1, 16'hFFFB, 16'h0000, 0, 0);
        cycle(0, 1, 16'h0300, 16'h0000, 0, 0);
        for (int i = 1; i <= 100; i++) cycle(0, 1, 16'($urandom), 16'h0000, 0, 0);
        check("mid_write_addr", 32'(bus.write_address), 32'd100);
        cycle(1, 1, 16'h0400, 16'h0000, 0, 0);
        check("mid_reset_we", 32'(bus.write_enable), 0);
        check("mid_reset_ri", 32'(bus.read_index), 0);
        cycle(0, 1, 16'hFFFB, 16'h0000, 0, 0);
        cycle(0, 1, 16'h0300, 16'h0000, 0, 0);
        check("restart_we", 32'(bus.write_enable), 1);
        check("restart_addr", 32'(bus.write_address), 32'h100);
        cycle(1, 0, 16'h0000, 16'h0000, 0, 0);

        // Constant-zero stream: only the auto-trigger can start a frame.
        nw = 0;
        for (int i = 0; i < AT; i++) begin
            cycle(0, 1, 16'h0000, 16'h0000, 0, 0);
            nw += int'(bus.write_enable);
        end
        check("auto_pre_writes", nw, 0);
        cycle(0, 1, 16'h0000, 16'h0000, 0, 0);
        check("auto_we", 32'(bus.write_enable), 32'(AUTO_EN));
        check("auto_addr", 32'(bus.write_address), AUTO_EN ? 32'h100 : 32'h0);
        check("auto_flag", 32'(bus.auto_trig), 32'(AUTO_EN));
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 16'h0000, 16'h0000, 0, 0);
        cycle(0, 0, 16'h0000, 16'h0000, 0, 1);
        cycle(0, 1, 16'hFFFB, 16'h0000, 0, 0);
        cycle(0, 1, 16'h0300, 16'h0000, 0, 0);
        check("real_trig_we", 32'(bus.write_enable), 1);
        check("auto_cleared", 32'(bus.auto_trig), 0);

        // Randomized traffic around the threshold, checked cycle by cycle by the model.
        cycle(1, 0, 16'h0000, 16'h0000, 0, 0);
        lvl = 16'h0000;
        fall = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 49) == 0) lvl = 16'($signed($urandom_range(0, 200)) - 100);
            if ($urandom_range(0, 79) == 0) fall = !fall;
            cycle(($urandom_range(0, 799) == 0), ($urandom_range(0, 2) != 0),
                  16'($signed($urandom_range(0, 400)) - 200), lvl, fall,
                  ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
